// File: rtl/decode_stage_hs.sv
// decode_stage_hs: instruction-decode stage for the in-order RV32I-style pipeline.
// Holds the integer register file (one writeback write port, two read ports),
// decodes I/S/B/U/J immediates and registers the decoded bundle behind a
// valid/ready output slice with flush and writeback-to-decode bypass.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   flush                      kill held bundle and any same-cycle capture
//   in_valid/in_ready          fetch handshake (in_ready = !out_valid || out_ready)
//   in_pc, in_instr            incoming PC and instruction word
//   wb_en, wb_rd, wb_data      register-file write port (x0 writes discarded)
//   out_valid/out_ready        execute handshake
//   out_pc, out_instr          registered PC / instruction
//   out_rs1, out_rs2, out_rd   register indices
//   out_rs1_data, out_rs2_data source operands (0 for x0)
//   out_imm                    sign-extended immediate
//   out_opcode/funct3/funct7   instruction fields
module decode_stage_hs #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RA_W      = 5,
  parameter int unsigned BYPASS_EN = 1,
  parameter int unsigned RF_CLEAR  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [RA_W-1:0] out_rs1,
  output logic [RA_W-1:0] out_rs2,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [RA_W-1:0] out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7
);

  localparam int unsigned NREG = 2**RA_W;

  // Register file
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic            wb_wr;

  assign wb_wr = wb_en && (wb_rd != '0);

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) rf_d[i] = rf_q[i];
    if (wb_wr) rf_d[wb_rd] = wb_data;
  end

  generate
    if (RF_CLEAR != 0) begin : g_rf_clear
      always_ff @(posedge clk or posedge reset) begin
        if (reset) rf_q <= '{default: '0};
        else       rf_q <= rf_d;
      end
    end else begin : g_rf_noclear
      always_ff @(posedge clk) rf_q <= rf_d;
    end
  endgenerate

  // Operand read with optional same-cycle forwarding
  logic [RA_W-1:0] rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_cap, rs2_cap;

  assign rs1_idx = RA_W'(in_instr[19:15]);
  assign rs2_idx = RA_W'(in_instr[24:20]);

  always_comb begin
    rs1_cap = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
    rs2_cap = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];
    if (BYPASS_EN != 0) begin
      if (wb_wr && (wb_rd == rs1_idx)) rs1_cap = wb_data;
      if (wb_wr && (wb_rd == rs2_idx)) rs2_cap = wb_data;
    end
  end

  // Immediate decode: build the 32-bit form, then sign-extend to XLEN
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;

  always_comb begin
    imm32 = '0;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      7'b0100011:
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      7'b1100011:
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                 in_instr[30:25], in_instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {in_instr[31:12], 12'b0};
      7'b1101111:
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                 in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_ext = XLEN'($signed(imm32));
  end

  // Output slice
  logic            out_valid_q,    out_valid_d;
  logic [XLEN-1:0] out_pc_q,       out_pc_d;
  logic [31:0]     out_instr_q,    out_instr_d;
  logic [XLEN-1:0] out_rs1_data_q, out_rs1_data_d;
  logic [XLEN-1:0] out_rs2_data_q, out_rs2_data_d;
  logic [XLEN-1:0] out_imm_q,      out_imm_d;
  logic            capture;

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    out_instr_d    = out_instr_q;
    out_rs1_data_d = out_rs1_data_q;
    out_rs2_data_d = out_rs2_data_q;
    out_imm_d      = out_imm_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d    = 1'b1;
      out_pc_d       = in_pc;
      out_instr_d    = in_instr;
      out_rs1_data_d = rs1_cap;
      out_rs2_data_d = rs2_cap;
      out_imm_d      = imm_ext;
    end else if (out_valid_q && !out_ready) begin
      // Held operands track writeback so the bundle never leaves stale.
      if (BYPASS_EN != 0) begin
        if (wb_wr && (wb_rd == out_rs1)) out_rs1_data_d = wb_data;
        if (wb_wr && (wb_rd == out_rs2)) out_rs2_data_d = wb_data;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_instr_q    <= '0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
      out_imm_q      <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_instr_q    <= out_instr_d;
      out_rs1_data_q <= out_rs1_data_d;
      out_rs2_data_q <= out_rs2_data_d;
      out_imm_q      <= out_imm_d;
    end
  end

  // Field outputs are slices of the registered instruction: same values as
  // registering each field separately, including the all-zero reset state.
  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_instr    = out_instr_q;
  assign out_rs1      = RA_W'(out_instr_q[19:15]);
  assign out_rs2      = RA_W'(out_instr_q[24:20]);
  assign out_rd       = RA_W'(out_instr_q[11:7]);
  assign out_opcode   = out_instr_q[6:0];
  assign out_funct3   = out_instr_q[14:12];
  assign out_funct7   = out_instr_q[31:25];
  assign out_rs1_data = out_rs1_data_q;
  assign out_rs2_data = out_rs2_data_q;
  assign out_imm      = out_imm_q;

endmodule

// File: tb/tb_decode_stage_hs.sv
module tb_decode_stage_hs;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, wb_en, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, wb_data, out_pc, out_instr;
  logic [31:0] out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  wb_rd, out_rs1, out_rs2, out_rd;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_rf [32];

  always #5 clk = ~clk;

  decode_stage_hs #(.XLEN(32), .RA_W(5), .BYPASS_EN(1), .RF_CLEAR(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mreg(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : model_rf[idx];
  endfunction

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
    in_valid = 1'b0;
    wb_en = 1'b1; wb_rd = rd; wb_data = d;
    tick();
    wb_en = 1'b0;
    if (rd != 5'd0) model_rf[rd] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ins;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;

    vecs[0]  = '{32'hFE000EE3, 32'h1000, 32'hFFFFFFFC}; // beq -4
    vecs[1]  = '{32'hFE000E63, 32'h1004, 32'hFFFFF7FC}; // B, imm[11]=0
    vecs[2]  = '{32'h8000006F, 32'h1008, 32'hFFF00000}; // J, only sign bit
    vecs[3]  = '{32'h123450B7, 32'h100C, 32'h12345000}; // LUI
    vecs[4]  = '{32'hFFFFF517, 32'h1010, 32'hFFFFF000}; // AUIPC
    vecs[5]  = '{32'hFE20AC23, 32'h1014, 32'hFFFFFFF8}; // sw x2,-8(x1)
    vecs[6]  = '{32'h7FF12183, 32'h1018, 32'h000007FF}; // lw x3,2047(x2)
    vecs[7]  = '{32'h000080E7, 32'h101C, 32'h00000000}; // jalr x1,0(x1)
    vecs[8]  = '{32'hFFF00093, 32'h1020, 32'hFFFFFFFF}; // addi x1,x0,-1
    vecs[9]  = '{32'hFFFFFFFF, 32'h1024, 32'h00000000}; // unknown opcode
    vecs[10] = '{32'h00528333, 32'h1028, 32'h00000000}; // R-type

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_rs1_data", out_rs1_data, 32'h0);
    chk("rst_ready", {31'b0, in_ready}, 32'h1);
    reset = 1'b0;

    // addi x1,x0,-1 straight after reset
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hFFF00093; out_ready = 1'b1;
    tick();
    chk("t1_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_imm", out_imm, 32'hFFFFFFFF);
    chk("t1_rd", {27'b0, out_rd}, 32'h1);
    chk("t1_rs1_data", out_rs1_data, 32'h0);
    chk("t1_pc", out_pc, 32'h100);
    in_valid = 1'b0;
    tick();
    chk("consume_valid", {31'b0, out_valid}, 32'h0);

    wb_write(5'd1, 32'h11111111);
    wb_write(5'd2, 32'h22222222);
    wb_write(5'd3, 32'h33333333);
    wb_write(5'd8, 32'h88888888);
    wb_write(5'd31, 32'hA5A5A5A5);

    // Table: one capture per cycle with out_ready held high
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc;
      ins = vecs[i].instr;
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
      chk($sformatf("v%0d_instr", i), out_instr, vecs[i].instr);
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, ins[11:7]});
      chk($sformatf("v%0d_opcode", i), {25'b0, out_opcode}, {25'b0, ins[6:0]});
      chk($sformatf("v%0d_funct3", i), {29'b0, out_funct3}, {29'b0, ins[14:12]});
      chk($sformatf("v%0d_funct7", i), {25'b0, out_funct7}, {25'b0, ins[31:25]});
      chk($sformatf("v%0d_rs1", i), {27'b0, out_rs1}, {27'b0, ins[19:15]});
      chk($sformatf("v%0d_rs2", i), {27'b0, out_rs2}, {27'b0, ins[24:20]});
      chk($sformatf("v%0d_rs1_data", i), out_rs1_data, mreg(ins[19:15]));
      chk($sformatf("v%0d_rs2_data", i), out_rs2_data, mreg(ins[24:20]));
    end
    in_valid = 1'b0;
    tick();

    // Bypass: write x5 while capturing add x6,x5,x5
    in_valid = 1'b1; in_instr = 32'h00528333; in_pc = 32'h200;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h00001234;
    tick();
    wb_en = 1'b0; model_rf[5] = 32'h00001234;
    chk("byp_rs1_data", out_rs1_data, 32'h00001234);
    chk("byp_rs2_data", out_rs2_data, 32'h00001234);

    // Hold three cycles with a new instruction waiting
    out_ready = 1'b0; in_instr = 32'h00108133; in_pc = 32'h300;
    #1;
    chk("hold_in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    chk("hold1_instr", out_instr, 32'h00528333);
    chk("hold1_pc", out_pc, 32'h200);
    chk("hold1_valid", {31'b0, out_valid}, 32'h1);
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h99999999;
    tick();
    wb_en = 1'b0; model_rf[9] = 32'h99999999;
    chk("hold2_unrelated_wb", out_rs1_data, 32'h00001234);
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000BEEF;
    tick();
    wb_en = 1'b0; model_rf[5] = 32'h0000BEEF;
    chk("hold3_rs1_refresh", out_rs1_data, 32'h0000BEEF);
    chk("hold3_rs2_refresh", out_rs2_data, 32'h0000BEEF);
    chk("hold3_instr", out_instr, 32'h00528333);
    chk("hold3_in_ready", {31'b0, in_ready}, 32'h0);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    chk("release_instr", out_instr, 32'h00108133);
    chk("release_pc", out_pc, 32'h300);
    chk("release_rs1_data", out_rs1_data, 32'h11111111);

    // Flush with a capture pending and a register write in the same cycle
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h000001B3; in_pc = 32'h400;
    wb_en = 1'b1; wb_rd = 5'd8; wb_data = 32'h0000CAFE;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    flush = 1'b0; wb_en = 1'b0; model_rf[8] = 32'h0000CAFE;
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    in_instr = 32'h008405B3; in_pc = 32'h404; // add x11,x8,x8
    tick();
    chk("post_flush_valid", {31'b0, out_valid}, 32'h1);
    chk("post_flush_instr", out_instr, 32'h008405B3);
    chk("post_flush_pc", out_pc, 32'h404);
    chk("flush_wb_kept", out_rs1_data, 32'h0000CAFE);

    // x0 writes are discarded, including the same-cycle forward
    wb_write(5'd0, 32'h0000DEAD);
    in_valid = 1'b1; in_instr = 32'h000001B3; in_pc = 32'h500; // add x3,x0,x0
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000DEAD;
    tick();
    wb_en = 1'b0;
    chk("x0_rs1_data", out_rs1_data, 32'h0);
    chk("x0_rs2_data", out_rs2_data, 32'h0);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'h0);

    // Asynchronous reset while holding
    in_valid = 1'b1; in_instr = 32'h00108133; in_pc = 32'h600;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("pre_rst_hold_valid", {31'b0, out_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("async_rst_instr", out_instr, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00108133; in_pc = 32'h700;
    tick();
    chk("rf_cleared_rs1", out_rs1_data, 32'h0);
    chk("rf_cleared_valid", {31'b0, out_valid}, 32'h1);
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
